// File: rtl/inst_decode_buf.sv
// Two-entry instruction buffer between fetch and decode; tags each entry with its immediate type.
// Optional illegal-opcode flagging is enabled by defining DECODE_ILLEGAL_EN.
module inst_decode_buf #(
    parameter int PC_W = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_flush,
    input  logic            i_if_valid,
    output logic            o_if_ready,
    input  logic [31:0]     i_inst,
    input  logic [PC_W-1:0] i_pc,
    output logic            o_id_valid,
    input  logic            i_id_ready,
    output logic [31:0]     o_inst,
    output logic [PC_W-1:0] o_pc,
    output logic [2:0]      o_imm_sel,
    output logic            o_illegal
);

    localparam logic [31:0] NOP_INST = 32'h00000013;

    function automatic logic [2:0] imm_sel_of(input logic [6:0] opc);
        case (opc)
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b1101111: return 3'b011;
            7'b0110111: return 3'b100;
            7'b0010111: return 3'b101;
            default:    return 3'b000;
        endcase
    endfunction

`ifdef DECODE_ILLEGAL_EN
    function automatic logic illegal_of(input logic [31:0] inst);
        logic known;
        case (inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111,
            7'b0110011, 7'b1110011: known = 1'b1;
            default:                known = 1'b0;
        endcase
        return (inst[1:0] != 2'b11) || !known;
    endfunction
`endif

    logic [31:0]     inst_q [0:1];
    logic [PC_W-1:0] pc_q   [0:1];
    logic [2:0]      imm_q  [0:1];
`ifdef DECODE_ILLEGAL_EN
    logic            ill_q  [0:1];
`endif
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;
    logic            push;
    logic            pop;
    logic            empty;

    // Handshakes depend only on the registered count, so ready never sees i_id_ready.
    assign empty      = (count == 2'd0);
    assign o_if_ready = (count != 2'd2);
    assign o_id_valid = !empty;
    assign push       = i_if_valid && o_if_ready;
    assign pop        = o_id_valid && i_id_ready;

    assign o_inst    = empty ? NOP_INST   : inst_q[rd_ptr];
    assign o_pc      = empty ? '0         : pc_q[rd_ptr];
    assign o_imm_sel = empty ? 3'b000     : imm_q[rd_ptr];
`ifdef DECODE_ILLEGAL_EN
    assign o_illegal = empty ? 1'b0       : ill_q[rd_ptr];
`else
    assign o_illegal = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
                imm_q[i]  <= '0;
`ifdef DECODE_ILLEGAL_EN
                ill_q[i]  <= 1'b0;
`endif
            end
        end else if (i_flush) begin
            // Flush wins over any same-cycle push or pop.
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                inst_q[wr_ptr] <= i_inst;
                pc_q[wr_ptr]   <= i_pc;
                imm_q[wr_ptr]  <= imm_sel_of(i_inst[6:0]);
`ifdef DECODE_ILLEGAL_EN
                ill_q[wr_ptr]  <= illegal_of(i_inst);
`endif
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
